// File: rtl/dpram_port_scheduler_if.sv
// Bundle between the port scheduler, its client requesters and the shared
// true dual-port RAM.
//   master : the scheduler. It takes requests and RAM read data, and drives
//            grants, responses, RAM pins and the collision counter.
//   slave  : the environment (client engines plus the RAM itself).
// Signals:
//   req_valid/req_we/req_addr/req_wdata  flat per-requester request fields
//   req_ready                            per-requester grant
//   rsp_valid/rsp_rdata                  per-requester read response
//   ram_addr_x/ram_data_x/ram_we_x       RAM port x command (x = a, b)
//   ram_q_x                              RAM port x registered read data
//   coll_count                           saturating count of withdrawn grants
interface dpram_port_scheduler_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_we;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            rsp_valid;
    logic [NREQ*DATA_WIDTH-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0]      ram_addr_a;
    logic [DATA_WIDTH-1:0]      ram_data_a;
    logic                       ram_we_a;
    logic [DATA_WIDTH-1:0]      ram_q_a;
    logic [ADDR_WIDTH-1:0]      ram_addr_b;
    logic [DATA_WIDTH-1:0]      ram_data_b;
    logic                       ram_we_b;
    logic [DATA_WIDTH-1:0]      ram_q_b;
    logic [CNT_WIDTH-1:0]       coll_count;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_addr_a, ram_data_a, ram_we_a,
        output ram_addr_b, ram_data_b, ram_we_b,
        output coll_count
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_addr_a, ram_data_a, ram_we_a,
        input  ram_addr_b, ram_data_b, ram_we_b,
        input  coll_count
    );
endinterface

// File: rtl/dpram_port_scheduler.sv
// Shares one single-clock true dual-port RAM (registered read data) between
// NREQ requesters. Each cycle up to two requests are granted round-robin:
// the first winner drives RAM port A, the second drives port B. A B winner
// that would race the A winner on the same address (at least one write) is
// withdrawn and counted. Read data returns to the issuing requester one
// cycle after its grant.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    dpram_port_scheduler_if.master (requests, responses, RAM pins,
//          collision counter)
module dpram_port_scheduler #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dpram_port_scheduler_if.master  bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NREQ];

    logic [IDX_W-1:0]      rr_ptr_p0;
    logic [NREQ-1:0]       rsp_valid_p0;
    logic [CNT_WIDTH-1:0]  coll_cnt_p0;
    logic                  rd_a_vld_p0;
    logic [IDX_W-1:0]      rd_a_own_p0;
    logic                  rd_b_vld_p0;
    logic [IDX_W-1:0]      rd_b_own_p0;
    logic [ADDR_WIDTH-1:0] hold_addr_a_p0;
    logic [DATA_WIDTH-1:0] hold_data_a_p0;
    logic [ADDR_WIDTH-1:0] hold_addr_b_p0;
    logic [DATA_WIDTH-1:0] hold_data_b_p0;

    logic                  a_found;
    logic [IDX_W-1:0]      a_idx;
    logic                  b_found;
    logic [IDX_W-1:0]      b_idx;
    logic                  hazard;
    logic                  b_grant;
    logic [NREQ-1:0]       grant_vec;
    logic [NREQ-1:0]       rd_vec;
    logic [IDX_W-1:0]      last_idx;
    logic [IDX_W-1:0]      next_ptr;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Stage 0: round-robin scan starting at rr_ptr, two winners
    always_comb begin
        logic [IDX_W-1:0] cand;
        a_found = 1'b0;
        a_idx   = '0;
        b_found = 1'b0;
        b_idx   = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_p0) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = cand;
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = cand;
                end
            end
        end
    end

    // Two reads of one address are harmless; anything involving a write is not.
    assign hazard  = a_found && b_found && (addr_arr[a_idx] == addr_arr[b_idx])
                     && (bus.req_we[a_idx] || bus.req_we[b_idx]);
    assign b_grant = b_found && !hazard;

    always_comb begin
        grant_vec = '0;
        if (a_found) grant_vec[a_idx] = 1'b1;
        if (b_grant) grant_vec[b_idx] = 1'b1;
    end

    assign rd_vec   = grant_vec & ~bus.req_we;
    assign last_idx = b_grant ? b_idx : a_idx;
    assign next_ptr = (last_idx == IDX_W'(NREQ - 1)) ? '0 : last_idx + 1'b1;

    assign bus.req_ready  = rst_n ? grant_vec : '0;
    assign bus.ram_we_a   = rst_n && a_found && bus.req_we[a_idx];
    assign bus.ram_addr_a = a_found ? addr_arr[a_idx]  : hold_addr_a_p0;
    assign bus.ram_data_a = a_found ? wdata_arr[a_idx] : hold_data_a_p0;
    // A withdrawn B winner leaves port B idle, exactly like no B winner.
    assign bus.ram_we_b   = rst_n && b_grant && bus.req_we[b_idx];
    assign bus.ram_addr_b = b_grant ? addr_arr[b_idx]  : hold_addr_b_p0;
    assign bus.ram_data_b = b_grant ? wdata_arr[b_idx] : hold_data_b_p0;

    // Stage 1: pointer advance, port-owner capture, collision count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_p0    <= '0;
            rsp_valid_p0 <= '0;
            coll_cnt_p0  <= '0;
            rd_a_vld_p0  <= 1'b0;
            rd_a_own_p0  <= '0;
            rd_b_vld_p0  <= 1'b0;
            rd_b_own_p0  <= '0;
        end else begin
            if (a_found) rr_ptr_p0 <= next_ptr;
            rsp_valid_p0 <= rd_vec;
            rd_a_vld_p0  <= a_found && !bus.req_we[a_idx];
            rd_a_own_p0  <= a_idx;
            rd_b_vld_p0  <= b_grant && !bus.req_we[b_idx];
            rd_b_own_p0  <= b_idx;
            if (hazard && (coll_cnt_p0 != '1)) coll_cnt_p0 <= coll_cnt_p0 + 1'b1;
        end
    end

    // Idle ports keep presenting the last address/data they carried.
    always_ff @(posedge clk) begin
        if (a_found) begin
            hold_addr_a_p0 <= addr_arr[a_idx];
            hold_data_a_p0 <= wdata_arr[a_idx];
        end
        if (b_grant) begin
            hold_addr_b_p0 <= addr_arr[b_idx];
            hold_data_b_p0 <= wdata_arr[b_idx];
        end
    end

    // Stage 2: steer RAM read data to the requester that owned each port.
    // The two ports never share an owner, so B simply overrides A.
    for (genvar g = 0; g < NREQ; g++) begin : g_rsp
        assign bus.rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] =
            (rd_b_vld_p0 && (rd_b_own_p0 == IDX_W'(g))) ? bus.ram_q_b : bus.ram_q_a;
    end

    assign bus.rsp_valid  = rsp_valid_p0;
    assign bus.coll_count = coll_cnt_p0;

endmodule

// File: tb/tb_dpram_port_scheduler.sv
// Directed bench for dpram_port_scheduler: a behavioural dual-port RAM sits
// behind the main instance; a second instance with a 2-bit counter exercises
// collision-count saturation.
module tb_dpram_port_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dpram_port_scheduler_if #(.NREQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(16)) bus ();
    dpram_port_scheduler_if #(.NREQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(2))  bus2 ();

    dpram_port_scheduler #(.NREQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dpram_port_scheduler #(.NREQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [64];
    always_ff @(posedge clk) begin
        if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
        if (bus.ram_we_b) mem[bus.ram_addr_b] <= bus.ram_data_b;
        bus.ram_q_a <= mem[bus.ram_addr_a];
        bus.ram_q_b <= mem[bus.ram_addr_b];
    end

    assign bus2.ram_q_a = '0;
    assign bus2.ram_q_b = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [5:0] addr, input logic [7:0] data);
        bus.req_valid[i]        = v;
        bus.req_we[i]           = we;
        bus.req_addr[i*6 +: 6]  = addr;
        bus.req_wdata[i*8 +: 8] = data;
    endtask

    function automatic logic [7:0] rdata(input int i);
        return bus.rsp_rdata[i*8 +: 8];
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus2.req_valid = '0;
        bus2.req_we    = '0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;

        // 1) reset with every requester asking to write
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_we    = 4'b1111;
        tick(); tick(); tick();
        chk("rst_ready",    64'(bus.req_ready), 64'h0);
        chk("rst_we_a",     64'(bus.ram_we_a), 64'h0);
        chk("rst_we_b",     64'(bus.ram_we_b), 64'h0);
        chk("rst_rsp",      64'(bus.rsp_valid), 64'h0);
        chk("rst_coll",     64'(bus.coll_count), 64'h0);
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        tick();

        // 2) dual write then dual read (rr_ptr = 0)
        set_req(0, 1'b1, 1'b1, 6'd0, 8'hAA);
        set_req(1, 1'b1, 1'b1, 6'd1, 8'hBB);
        #1;
        chk("dw_ready",  64'(bus.req_ready), 64'h3);
        chk("dw_we_a",   64'(bus.ram_we_a), 64'h1);
        chk("dw_addr_a", 64'(bus.ram_addr_a), 64'h0);
        chk("dw_data_a", 64'(bus.ram_data_a), 64'hAA);
        chk("dw_we_b",   64'(bus.ram_we_b), 64'h1);
        chk("dw_addr_b", 64'(bus.ram_addr_b), 64'h1);
        chk("dw_data_b", 64'(bus.ram_data_b), 64'hBB);
        tick();
        chk("dw_no_rsp", 64'(bus.rsp_valid), 64'h0);
        set_req(0, 1'b1, 1'b0, 6'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 6'd1, 8'h00);
        #1;
        chk("dr_ready", 64'(bus.req_ready), 64'h3);
        tick();
        chk("dr_rsp",    64'(bus.rsp_valid), 64'h3);
        chk("dr_data0",  64'(rdata(0)), 64'hAA);
        chk("dr_data1",  64'(rdata(1)), 64'hBB);

        // 3) write-write collision at addr 5 (rr_ptr = 2, so r0 on A, r1 on B)
        set_req(0, 1'b1, 1'b1, 6'd5, 8'hCC);
        set_req(1, 1'b1, 1'b1, 6'd5, 8'hDD);
        #1;
        chk("ww_ready", 64'(bus.req_ready), 64'h1);
        chk("ww_we_a",  64'(bus.ram_we_a), 64'h1);
        chk("ww_we_b",  64'(bus.ram_we_b), 64'h0);
        tick();
        chk("ww_coll",  64'(bus.coll_count), 64'h1);
        set_req(0, 1'b0, 1'b0, 6'd0, 8'h00);
        #1;
        chk("ww2_ready",  64'(bus.req_ready), 64'h2);
        chk("ww2_addr_a", 64'(bus.ram_addr_a), 64'h5);
        chk("ww2_data_a", 64'(bus.ram_data_a), 64'hDD);
        chk("ww2_we_a",   64'(bus.ram_we_a), 64'h1);
        chk("ww2_we_b",   64'(bus.ram_we_b), 64'h0);
        tick();
        set_req(1, 1'b0, 1'b0, 6'd0, 8'h00);
        set_req(3, 1'b1, 1'b0, 6'd5, 8'h00);
        #1;
        chk("ww3_ready", 64'(bus.req_ready), 64'h8);
        tick();
        chk("ww3_rsp",  64'(bus.rsp_valid), 64'h8);
        chk("ww3_data", 64'(rdata(3)), 64'hDD);
        chk("ww3_coll", 64'(bus.coll_count), 64'h1);

        // 4) fairness: all four read continuously, rr_ptr now 0
        set_req(0, 1'b1, 1'b0, 6'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 6'd1, 8'h00);
        set_req(2, 1'b1, 1'b0, 6'd0, 8'h00);
        set_req(3, 1'b1, 1'b0, 6'd1, 8'h00);
        #1;
        chk("fair1_ready", 64'(bus.req_ready), 64'h3);
        tick();
        chk("fair2_ready", 64'(bus.req_ready), 64'hC);
        chk("fair2_rsp",   64'(bus.rsp_valid), 64'h3);
        chk("fair2_d0",    64'(rdata(0)), 64'hAA);
        chk("fair2_d1",    64'(rdata(1)), 64'hBB);
        tick();
        chk("fair3_ready", 64'(bus.req_ready), 64'h3);
        chk("fair3_rsp",   64'(bus.rsp_valid), 64'hC);
        chk("fair3_d2",    64'(rdata(2)), 64'hAA);
        chk("fair3_d3",    64'(rdata(3)), 64'hBB);
        tick();
        chk("fair4_ready", 64'(bus.req_ready), 64'hC);
        chk("fair4_rsp",   64'(bus.rsp_valid), 64'h3);
        tick();
        bus.req_valid = '0;
        chk("fair5_rsp",   64'(bus.rsp_valid), 64'hC);
        tick();
        chk("fair_idle_rsp", 64'(bus.rsp_valid), 64'h0);

        // 5) same-address reads; first place 0x5A at addr 9 (rr_ptr = 0)
        set_req(2, 1'b1, 1'b1, 6'd9, 8'h5A);
        #1;
        chk("sa_wr_ready", 64'(bus.req_ready), 64'h4);
        tick();
        set_req(2, 1'b1, 1'b0, 6'd9, 8'h00);
        set_req(3, 1'b1, 1'b0, 6'd9, 8'h00);
        #1;
        chk("sa_ready", 64'(bus.req_ready), 64'hC);
        chk("sa_we_b",  64'(bus.ram_we_b), 64'h0);
        tick();
        bus.req_valid = '0;
        chk("sa_rsp",   64'(bus.rsp_valid), 64'hC);
        chk("sa_d2",    64'(rdata(2)), 64'h5A);
        chk("sa_d3",    64'(rdata(3)), 64'h5A);
        chk("sa_coll",  64'(bus.coll_count), 64'h1);

        // reset arriving with a read pending
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 6'd0, 8'h00);
        #1;
        chk("mr_ready", 64'(bus.req_ready), 64'h0);
        tick();
        chk("mr_rsp",  64'(bus.rsp_valid), 64'h0);
        chk("mr_coll", 64'(bus.coll_count), 64'h0);
        rst_n = 1'b1;
        bus.req_valid = '0;
        tick();
        chk("mr_post_rsp", 64'(bus.rsp_valid), 64'h0);

        // 6) saturation on the 2-bit counter instance
        bus2.req_valid            = 4'b0011;
        bus2.req_we               = 4'b0011;
        bus2.req_addr[0 +: 6]     = 6'd5;
        bus2.req_addr[6 +: 6]     = 6'd5;
        tick(); tick();
        chk("sat_two",  64'(bus2.coll_count), 64'h2);
        tick(); tick(); tick();
        chk("sat_five", 64'(bus2.coll_count), 64'h3);
        bus2.req_valid = '0;
        tick();
        chk("sat_hold", 64'(bus2.coll_count), 64'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
